// File: rtl/coef_loader_pkg.sv
// ============================================================================
// Module      : coef_loader_pkg
// Description : Shared constants and state encoding for the coefficient loader
//               and the blocks that consume its coefficients.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package coef_loader_pkg;

    localparam int         C_N_COEF      = 16;
    localparam int         C_COEF_W      = 12;
    localparam logic [7:0] C_HDR_BYTE    = 8'hA5;
    localparam int         C_TIMEOUT_CYC = 1_000_000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_HDR = 3'd1,
        S_HI       = 3'd2,
        S_LO       = 3'd3,
        S_CHK      = 3'd4,
        S_COMMIT   = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/coef_loader_timeout.sv
// ============================================================================
// Module      : coef_loader_timeout
// Description : Loadable down-counter with clear and expire flag, used as an
//               inter-byte watchdog by UART-driven controllers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coef_loader_timeout
    import coef_loader_pkg::*;
#(
    parameter int LOAD_VAL = C_TIMEOUT_CYC - 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_clr,
    input  logic i_dec,
    output logic o_expire
);

    localparam int CNT_W = cnt_width(LOAD_VAL);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(LOAD_VAL);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/coef_loader.sv
// ============================================================================
// Module      : coef_loader
// Description : Parses a framed UART packet (header, N_COEF 2-byte coefficients,
//               XOR checksum) into the shadow coefficient bank and commits it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coef_loader
    import coef_loader_pkg::*;
#(
    parameter int         N_COEF      = C_N_COEF,
    parameter int         COEF_W      = C_COEF_W,
    parameter logic [7:0] HDR_BYTE    = C_HDR_BYTE,
    parameter int         TIMEOUT_CYC = C_TIMEOUT_CYC
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_valid_i,
    output logic                      coef_we_o,
    output logic [$clog2(N_COEF)-1:0] coef_addr_o,
    output logic [COEF_W-1:0]         coef_data_o,
    output logic                      commit_o,
    output logic                      fir_hold_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o
);

    localparam int AW   = $clog2(N_COEF);
    localparam int HI_W = COEF_W - 8;

    state_t            r_state;
    logic [AW-1:0]     r_idx;
    logic [7:0]        r_csum;
    logic [HI_W-1:0]   r_hi;
    logic              r_coef_we;
    logic [AW-1:0]     r_coef_addr;
    logic [COEF_W-1:0] r_coef_data;
    logic              r_commit;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic w_active;
    logic w_tmo_load;
    logic w_tmo_clr;
    logic w_tmo_dec;
    logic w_tmo_zero;
    logic w_expire;

    // The watchdog only runs between bytes of the data/checksum phase.
    assign w_active   = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_CHK);
    assign w_tmo_load = ((r_state == S_IDLE) && start_i) ||
                        ((r_state != S_IDLE) && rx_valid_i);
    assign w_tmo_clr  = (r_state == S_COMMIT) || (r_state == S_ERR);
    assign w_tmo_dec  = w_active && !rx_valid_i;
    assign w_expire   = w_tmo_dec && w_tmo_zero;

    coef_loader_timeout #(
        .LOAD_VAL (TIMEOUT_CYC - 1)
    ) u_timeout (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_load   (w_tmo_load),
        .i_clr    (w_tmo_clr),
        .i_dec    (w_tmo_dec),
        .o_expire (w_tmo_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_csum      <= '0;
            r_hi        <= '0;
            r_coef_we   <= 1'b0;
            r_coef_addr <= '0;
            r_coef_data <= '0;
            r_commit    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_coef_we <= 1'b0;
            r_commit  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_WAIT_HDR;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                        r_csum  <= '0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                S_WAIT_HDR: begin
                    if (rx_valid_i && (rx_data_i == HDR_BYTE)) begin
                        r_state <= S_HI;
                    end
                end
                S_HI: begin
                    if (rx_valid_i) begin
                        r_hi    <= rx_data_i[HI_W-1:0];
                        r_csum  <= r_csum ^ rx_data_i;
                        r_state <= S_LO;
                    end else if (w_expire) begin
                        r_state <= S_ERR;
                    end
                end
                S_LO: begin
                    if (rx_valid_i) begin
                        r_csum      <= r_csum ^ rx_data_i;
                        r_coef_we   <= 1'b1;
                        r_coef_addr <= r_idx;
                        r_coef_data <= {r_hi, rx_data_i};
                        if (r_idx == AW'(N_COEF - 1)) begin
                            r_state <= S_CHK;
                        end else begin
                            r_idx   <= r_idx + AW'(1);
                            r_state <= S_HI;
                        end
                    end else if (w_expire) begin
                        r_state <= S_ERR;
                    end
                end
                S_CHK: begin
                    if (rx_valid_i) begin
                        r_state <= (rx_data_i == r_csum) ? S_COMMIT : S_ERR;
                    end else if (w_expire) begin
                        r_state <= S_ERR;
                    end
                end
                S_COMMIT: begin
                    r_commit <= 1'b1;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                S_ERR: begin
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign coef_we_o   = r_coef_we;
    assign coef_addr_o = r_coef_addr;
    assign coef_data_o = r_coef_data;
    assign commit_o    = r_commit;
    assign fir_hold_o  = r_busy;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign error_o     = r_err;

endmodule

`default_nettype wire

// File: doc/coef_loader.md
Name: coef_loader

Overview:
- Configures the FIR coefficient bank from the UART receive byte stream.
- Parses a framed packet: header, 16 coefficients of 2 bytes each, then an XOR checksum.
- Writes each coefficient into the shadow registers of the coefficient block. Pulses commit only when the checksum matches.
- Holds the FIR disabled while loading. Sits between the UART RX and the coefficient block, and is started by the coefficient-load pushbutton path.

Parameters:
N_COEF, 16, number of coefficients per frame
COEF_W, 12, coefficient width in bits (signed two's complement)
HDR_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 1_000_000, max idle cycles between bytes inside a frame

Ports:
clk_i  in  1  system clock; single clock domain
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  single-cycle pulse (debounced pushbutton); arms a load
rx_data_i  in  8  received UART byte
rx_valid_i  in  1  one-cycle strobe; rx_data_i valid
coef_we_o  out  1  shadow-register write strobe
coef_addr_o  out  $clog2(N_COEF)  coefficient index being written
coef_data_o  out  COEF_W  coefficient value
commit_o  out  1  one-cycle pulse; copy shadow bank into active bank
fir_hold_o  out  1  high while loading; FIR must not consume coefficients
busy_o  out  1  frame in progress
done_o  out  1  sticky; last frame committed OK
error_o  out  1  sticky; last frame aborted (bad checksum or timeout)

Behaviour:
- Reset values: every output 0. State IDLE; index, checksum and timeout counter 0. Reset mid-frame aborts with no commit and no further writes.
- Output timing: all outputs registered.
- fir_hold_o = busy_o, high in every state except IDLE.
- States: IDLE, WAIT_HDR, HI, LO, CHK, COMMIT, ERR.
- IDLE:
  - start_i -> WAIT_HDR; clear index, checksum, timeout counter, done_o, error_o.
  - rx_valid_i in IDLE is ignored, including in the same cycle as start_i.
- WAIT_HDR:
  - rx_valid_i with rx_data_i==HDR_BYTE -> HI.
  - Any other byte is discarded and the state is held.
  - No timeout applies in this state.
- HI:
  - On rx_valid_i, latch rx_data_i[3:0] as coefficient bits [11:8]; bits [7:4] are ignored.
  - checksum ^= rx_data_i; -> LO.
- LO:
  - On rx_valid_i, checksum ^= rx_data_i.
  - Next cycle: coef_we_o=1 for exactly one cycle, coef_addr_o=index, coef_data_o={hi_nibble, rx_data_i}.
  - If index==N_COEF-1 -> CHK, else index++ and -> HI.
  - coef_addr_o and coef_data_o hold their value between writes.
- CHK: on rx_valid_i, rx_data_i==checksum -> COMMIT, else -> ERR. The checksum covers the 2*N_COEF data bytes only, not the header.
- COMMIT: commit_o=1 for one cycle; done_o set; -> IDLE.
- ERR: error_o set; no commit_o; -> IDLE. Shadow contents are left partially written; the active bank is untouched.
- Timeout:
  - Counter is active in HI, LO and CHK. It clears on every rx_valid_i and increments otherwise.
  - Reaching TIMEOUT_CYC-1 -> ERR.
  - If rx_valid_i and timeout expiry coincide, the byte wins and the counter clears.
- start_i while busy_o=1 is ignored.
- Latency from final checksum byte strobe to commit_o is 2 cycles (CHK evaluates, COMMIT registers).
- Throughput: accepts one byte per cycle if rx_valid_i is back-to-back.

Decomposition:
- Shared package holds:
  - state enum localparams (IDLE..ERR);
  - HDR_BYTE default;
  - N_COEF and COEF_W, so the coefficient block, FIR and loader agree.
- Sub-module coef_loader_timeout: a loadable down-counter with a clear input and an expire flag, reusable by other UART-driven controllers.
- The rest stays in one FSM module.

Test Plan:
- Nominal frame: start_i, then A5, then for k=0..15 send 01 then k, then checksum 00 -> 16 writes addr k / data 0x100+k; commit_o one cycle, 2 cycles after checksum strobe; done_o=1, error_o=0; fir_hold_o high from start until COMMIT.
- Bad checksum: same frame with checksum 01 -> 16 writes, no commit_o, error_o=1, done_o=0, busy_o=0.
- Garbage prefix plus ignored nibble: start, then bytes 00 FF 5A, then A5, then coefficient 0 sent as F7 3C with the rest per nominal, checksum recomputed -> garbage ignored; addr 0 data 0x73C; commit_o occurs.
- Timeout: TIMEOUT_CYC=20; start, A5, 01, then silence 20 cycles -> error_o=1, no further coef_we_o. A byte arriving on the expiry cycle instead keeps the frame alive.
- Reset mid-frame: assert rst_i one cycle after the 5th coef_we_o -> all outputs 0 next cycle, state IDLE; a following nominal frame loads and commits cleanly.
- Busy start and back-to-back bytes: start_i pulsed during LO, with bytes sent with rx_valid_i held high every cycle -> start ignored; all 16 writes one per 2 cycles; commit_o occurs.
